// File: rtl/ctl_trigger_pkg.sv
// Shared state encoding and widths for the multi-player light-gun trigger controller.
package ctl_trigger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_COOLDOWN
    } trig_state_t;

    localparam int AMMO_W      = 4;
    localparam int FRAME_CNT_W = 8;
    localparam int DEB_CNT_W   = 10;

    // Terminal value of an up-counter that must see `frames` new_frame pulses.
    function automatic logic [FRAME_CNT_W-1:0] last_count(input int frames);
        return (frames > 0) ? FRAME_CNT_W'(frames - 1) : '0;
    endfunction

endpackage

// File: rtl/trigger_channel.sv
// One player channel: trigger conditioning, shot/settle/sample/cooldown sequencing and ammo.
// Define CTL_TRIGGER_MP_DEBOUNCE_EN to filter the trigger level over DEB_CYCLES samples.
module trigger_channel
    import ctl_trigger_pkg::*;
#(
    parameter int SETTLE_FRAMES   = 10,
    parameter int COOLDOWN_FRAMES = 4,
    parameter int AMMO_MAX        = 3,
    parameter int DEB_CYCLES      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              new_frame,
    input  logic              gun_sel,
    input  logic              gun_trigger,
    input  logic              gun_photodetector,
    input  logic              mouse_on_target,
    input  logic              mouse_left,
    input  logic              reload,
    output logic              shot_fired,
    output logic              hit,
    output logic              miss,
    output logic              dry_fire,
    output logic              busy,
    output logic [AMMO_W-1:0] ammo
);

    localparam logic [AMMO_W-1:0]      AMMO_FULL   = AMMO_W'(AMMO_MAX);
    localparam logic [FRAME_CNT_W-1:0] SETTLE_LAST = last_count(SETTLE_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] COOL_LAST   = last_count(COOLDOWN_FRAMES);

    logic trig_meta;
    logic trig_sync;
    logic raw_level;
    logic trig_level;
    logic trig_prev;
    logic shot_event;
    logic detector;
    logic sel_changed;
    logic gun_sel_q;

    trig_state_t            state;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    // The gun trigger is active-low and asynchronous, so both flops reset to "released".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_meta <= 1'b1;
            trig_sync <= 1'b1;
        end else begin
            trig_meta <= gun_trigger;
            trig_sync <= trig_meta;
        end
    end

    assign raw_level = gun_sel ? ~trig_sync : mouse_left;

`ifdef CTL_TRIGGER_MP_DEBOUNCE_EN
    localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEB_CYCLES - 1);

    logic                 deb_level;
    logic [DEB_CNT_W-1:0] deb_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_level <= 1'b0;
            deb_cnt   <= '0;
        end else if (raw_level == deb_level) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            deb_level <= raw_level;
            deb_cnt   <= '0;
        end else begin
            deb_cnt <= deb_cnt + DEB_CNT_W'(1);
        end
    end

    assign trig_level = deb_level;
`else
    localparam int unused_deb_cycles = DEB_CYCLES;

    assign trig_level = raw_level;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) trig_prev <= 1'b0;
        else     trig_prev <= trig_level;
    end

    // A shot is the release of the trigger, not the press.
    assign shot_event  = trig_prev & ~trig_level;
    assign detector    = gun_sel ? gun_photodetector : mouse_on_target;
    assign sel_changed = gun_sel != gun_sel_q;
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            frame_cnt  <= '0;
            ammo       <= AMMO_FULL;
            gun_sel_q  <= 1'b0;
            shot_fired <= 1'b0;
            hit        <= 1'b0;
            miss       <= 1'b0;
            dry_fire   <= 1'b0;
        end else begin
            shot_fired <= 1'b0;
            hit        <= 1'b0;
            miss       <= 1'b0;
            dry_fire   <= 1'b0;
            gun_sel_q  <= gun_sel;
            if (reload)
                ammo <= AMMO_FULL;
            case (state)
                ST_IDLE: begin
                    if (shot_event) begin
                        if (ammo != '0) begin
                            shot_fired <= 1'b1;
                            ammo       <= (reload ? AMMO_FULL : ammo) - AMMO_W'(1);
                            frame_cnt  <= '0;
                            state      <= ST_SETTLE;
                        end else begin
                            dry_fire <= 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (sel_changed) begin
                        frame_cnt <= '0;
                        state     <= ST_IDLE;
                    end else if (SETTLE_FRAMES == 0 || (new_frame && frame_cnt == SETTLE_LAST)) begin
                        frame_cnt <= '0;
                        state     <= ST_SAMPLE;
                    end else if (new_frame) begin
                        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (sel_changed) begin
                        state <= ST_IDLE;
                    end else begin
                        hit       <= detector;
                        miss      <= ~detector;
                        frame_cnt <= '0;
                        state     <= ST_COOLDOWN;
                    end
                end
                ST_COOLDOWN: begin
                    if (COOLDOWN_FRAMES == 0 || (new_frame && frame_cnt == COOL_LAST)) begin
                        frame_cnt <= '0;
                        state     <= ST_IDLE;
                    end else if (new_frame) begin
                        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ctl_trigger_mp.sv
// Multi-player trigger controller: N_CH fully independent trigger_channel instances.
// Optional trigger debounce is enabled with CTL_TRIGGER_MP_DEBOUNCE_EN.
module ctl_trigger_mp
    import ctl_trigger_pkg::*;
#(
    parameter int N_CH            = 2,
    parameter int SETTLE_FRAMES   = 10,
    parameter int COOLDOWN_FRAMES = 4,
    parameter int AMMO_MAX        = 3,
    parameter int DEB_CYCLES      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         new_frame,
    input  logic [N_CH-1:0]              gun_is_connected,
    input  logic [N_CH-1:0]              gun_trigger,
    input  logic [N_CH-1:0]              gun_photodetector,
    input  logic [N_CH-1:0]              mouse_on_target,
    input  logic [N_CH-1:0]              mouse_left,
    input  logic [N_CH-1:0]              reload,
    output logic [N_CH-1:0]              shot_fired,
    output logic [N_CH-1:0]              hit,
    output logic [N_CH-1:0]              miss,
    output logic [N_CH-1:0]              dry_fire,
    output logic [N_CH-1:0]              busy,
    output logic [N_CH-1:0][AMMO_W-1:0]  ammo
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        trigger_channel #(
            .SETTLE_FRAMES   (SETTLE_FRAMES),
            .COOLDOWN_FRAMES (COOLDOWN_FRAMES),
            .AMMO_MAX        (AMMO_MAX),
            .DEB_CYCLES      (DEB_CYCLES)
        ) u_channel (
            .clk               (clk),
            .rst               (rst),
            .new_frame         (new_frame),
            .gun_sel           (gun_is_connected[i]),
            .gun_trigger       (gun_trigger[i]),
            .gun_photodetector (gun_photodetector[i]),
            .mouse_on_target   (mouse_on_target[i]),
            .mouse_left        (mouse_left[i]),
            .reload            (reload[i]),
            .shot_fired        (shot_fired[i]),
            .hit               (hit[i]),
            .miss              (miss[i]),
            .dry_fire          (dry_fire[i]),
            .busy              (busy[i]),
            .ammo              (ammo[i])
        );
    end

endmodule
